// File: rtl/jpeg_enc_pkg.sv
// Shared constants and types for the JPEG encoder block-buffer control path.
package jpeg_enc_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int DEPTH      = 64;
  localparam int BANKS      = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

endpackage

// File: rtl/jpeg_bank_state.sv
// Occupancy tracker for one pixel buffer bank: EMPTY -> FILLING -> FULL -> EMPTY.
module jpeg_bank_state
  import jpeg_enc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fill_start,
  input  logic        fill_done,
  input  logic        ack,
  output bank_state_t state
);

  bank_state_t state_next;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a single-pixel block may go straight from EMPTY to FULL
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (fill_done) begin
          state_next = FULL;
        end else if (fill_start) begin
          state_next = FILLING;
        end
      end
      FILLING: begin
        if (fill_done) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (ack) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: rtl/jpeg_pingpong_block_ctrl.sv
// Ping-pong controller for two pixel block buffers between the pixel stream
// and the block (level shift / DCT) stage.
// Optional feature: define JPEG_BLK_CNT_EN to build the completed-block
// counter and expose the blk_count port.
module jpeg_pingpong_block_ctrl #(
  parameter int DATA_WIDTH = jpeg_enc_pkg::DATA_WIDTH,
  parameter int DEPTH      = jpeg_enc_pkg::DEPTH
`ifdef JPEG_BLK_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [1:0]            wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  blk_valid,
  output logic                  blk_sel,
  input  logic                  blk_ack,
  output logic                  busy
`ifdef JPEG_BLK_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  blk_count
`endif
);

  import jpeg_enc_pkg::*;

  localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [PW-1:0] pix_cnt;
  bank_state_t   state [BANKS];

  logic          accept;
  logic          ack_take;
  logic          last_pix;
  logic [1:0]    fill_start;
  logic [1:0]    fill_done;
  logic [1:0]    ack_bank;
  logic [1:0]    full_next;
  logic          rd_next;
  logic          blk_valid_next;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    jpeg_bank_state u_bank (
      .clock      (clock),
      .reset_n    (reset_n),
      .fill_start (fill_start[b]),
      .fill_done  (fill_done[b]),
      .ack        (ack_bank[b]),
      .state      (state[b])
    );
  end

  // Handshake, bank steering and look-ahead of which bank is presented next
  always_comb begin
    s_ready    = (state[wr_bank] != FULL);
    // Writes are suppressed while reset is held so the buffers stay idle.
    accept     = s_valid & s_ready & reset_n;
    ack_take   = blk_valid & blk_ack;
    last_pix   = (pix_cnt == LAST);
    wr_en      = '0;
    wr_data    = '0;
    fill_start = '0;
    fill_done  = '0;
    ack_bank   = '0;
    if (accept) begin
      wr_en[wr_bank]      = 1'b1;
      wr_data             = s_data;
      fill_start[wr_bank] = (state[wr_bank] == EMPTY);
      fill_done[wr_bank]  = last_pix;
    end
    if (ack_take) begin
      ack_bank[rd_bank] = 1'b1;
    end
    // blk_valid is registered, so it is derived from the bank states as they
    // will be after this edge; this gives one cycle from last pixel to valid.
    for (int b = 0; b < BANKS; b++) begin
      full_next[b] = ((state[b] == FULL) & ~ack_bank[b]) | fill_done[b];
    end
    rd_next        = rd_bank ^ ack_take;
    blk_valid_next = full_next[rd_next];
  end

  // Pointers, pixel counter and presented-block flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      pix_cnt   <= '0;
      blk_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (last_pix) begin
          pix_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end
      rd_bank   <= rd_next;
      blk_valid <= blk_valid_next;
    end
  end

  assign blk_sel = rd_bank;
  assign busy    = (state[0] != EMPTY) | (state[1] != EMPTY);

`ifdef JPEG_BLK_CNT_EN
  // Completed-block counter, wraps naturally at its width
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_count <= '0;
    end else if (ack_take) begin
      blk_count <= blk_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/jpeg_pingpong_block_ctrl.md
Name: jpeg_pingpong_block_ctrl

Overview:
Controller that sequences two 64x12-bit pixel buffers (bank 0 / bank 1) as a ping-pong pair between the pixel stream and the block stage (level shift/DCT) in the JPEG encoder. It accepts a valid/ready pixel stream and steers each accepted pixel into the fill bank via that buffer's 1-pixel write enable. It presents each completed 8x8 block to the downstream stage while filling the other bank.

Parameters:
DATA_WIDTH, 12, pixel width
DEPTH, 64, pixels per block (power of 2)
CNT_WIDTH, 16, width of completed-block counter (optional feature only)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
s_valid  input  1  pixel stream valid
s_ready  output  1  pixel stream ready
s_data  input  DATA_WIDTH  pixel value
wr_en  output  2  per-bank 1-pixel write enable, bit b drives bank b input_1pix_enable
wr_data  output  DATA_WIDTH  pixel data to both banks
blk_valid  output  1  a full block is available in bank blk_sel
blk_sel  output  1  bank index holding the presented block
blk_ack  input  1  downstream has consumed the presented block
busy  output  1  any bank not EMPTY
blk_count  output  CNT_WIDTH  completed blocks (BLK_CNT_EN only)

Behaviour:
- One clock domain. Reset is asynchronous, active-low. Ports are named clock and reset_n.
- Reset values: all bank states EMPTY, wr_bank=0, rd_bank=0, pix_cnt=0, s_ready=1, wr_en=0, wr_data=0, blk_valid=0, blk_sel=0, busy=0, blk_count=0.
- Per-bank state: EMPTY -> FILLING (first pixel accepted) -> FULL (DEPTH-th pixel accepted) -> EMPTY (blk_ack while presented).
- s_ready is combinational: 1 iff state[wr_bank] is EMPTY or FILLING.
- A pixel is accepted when s_valid & s_ready. On acceptance:
  - wr_en[wr_bank]=1 and wr_data=s_data are driven combinationally in the same cycle; the buffer captures the pixel at that edge.
  - pix_cnt increments (6-bit for DEPTH=64). When pix_cnt==DEPTH-1, pix_cnt wraps to 0, state[wr_bank] becomes FULL and wr_bank toggles.
- Exactly DEPTH writes per bank per block. This keeps each buffer's internal write index aligned. No partial-block flush exists; only reset realigns.
- blk_valid is registered: it rises the cycle after the edge where the bank became FULL. The buffer contents are already final at that point. Latency from the 64th accepted pixel to blk_valid is 1 cycle.
- blk_sel=rd_bank. blk_valid stays high and blk_sel stays stable until blk_ack is seen.
- When blk_valid & blk_ack: state[rd_bank] becomes EMPTY, rd_bank toggles, and blk_valid drops next cycle unless the other bank is FULL. If it is, blk_valid stays 1 and blk_sel flips. blk_ack while blk_valid=0 is ignored.
- Simultaneous last-pixel write to bank X and ack of bank Y (X≠Y): both take effect in that cycle.
- Both banks FULL: s_ready=0 and stream stalls. On the ack cycle s_ready stays 0; it rises the next cycle.
- busy = any state ≠ EMPTY.
- Reset asserted mid-block: immediate return to reset values. Bank contents are don't-care because the buffers share reset_n.

Optional Feature:
Macro JPEG_BLK_CNT_EN.
- Defined: blk_count increments by 1 on each blk_valid & blk_ack and wraps modulo 2^CNT_WIDTH.
- Undefined: the blk_count port is absent and no counter logic is built.

Decomposition:
- Shared package jpeg_enc_pkg: DATA_WIDTH/DEPTH constants, bank_state_t enum {EMPTY, FILLING, FULL}, BANKS=2.
- One sub-module is natural: jpeg_bank_state, a per-bank 3-state FSM with inputs fill_start, fill_done, ack and output state. It is instantiated twice.
- Pointer, counter and handshake logic stay in the top module.

Test Plan:
- Stream pixels 0..63 continuously with blk_ack=0 -> wr_en=2'b01 for 64 cycles; blk_valid=1, blk_sel=0 one cycle after pixel 63; bank 0 buffer_768bits top 12 bits=0x000, bottom 12 bits=0x03F.
- Stream 128 pixels with no ack -> bank 1 fills via wr_en=2'b10; s_ready=0 after pixel 127; pixel 128 held; blk_sel stays 0.
- From the both-FULL state, pulse blk_ack 1 cycle -> blk_valid stays 1, blk_sel=1, s_ready=1 next cycle, and the stalled pixel is written to bank 0.
- Last pixel of bank 1 accepted in the same cycle as blk_ack for bank 0 -> bank 0 EMPTY, bank 1 FULL, blk_valid stays 1, blk_sel=1, no lost or duplicate write.
- Assert reset_n=0 after pixel 30 of a block -> s_ready=1, blk_valid=0, busy=0 immediately; after release the next 64 pixels form one block in bank 0.
- JPEG_BLK_CNT_EN: 5 blocks streamed and acked -> blk_count=5; with CNT_WIDTH=2 -> blk_count=1.
